stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap/clear controller: button conditioning, control FSM,
// deci-second tick prescaler, chain clear and lap-snapshot display select.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned DEB_DIV  = 1_048_576,
    parameter int unsigned DEB_LEN  = 5
) (
    input  logic        clk0,
    input  logic        reset_sw,
    input  logic        start_sw,
    input  logic        lap_sw,
    input  logic [15:0] cnt_bcd,
    input  logic        ovf,
    output logic        tick,
    output logic        clr,
    output logic [15:0] disp_bcd,
    output logic [1:0]  state,
    output logic        ovf_flag
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_LAP  = 2'b10;
    localparam logic [1:0] ST_STOP = 2'b11;

    localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
    localparam logic [20:0] DEB_LAST  = 21'(DEB_DIV - 1);

    // Index 0 is the start button, index 1 the lap button.
    logic [1:0]         w_raw;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [DEB_LEN-1:0] r_sh [2];
    logic [1:0]         r_db;
    logic [1:0]         r_db_d;
    logic [20:0]        r_deb_cnt;
    logic               w_deb_stb;
    logic [1:0]         w_press;
    logic               w_p_start;
    logic               w_p_lap;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nx;
    logic        r_clr;
    logic        w_clr_nx;
    logic        w_snap_ld;
    logic        w_flag_set;
    logic        w_flag_clr;
    logic        r_ovf_flag;
    logic [15:0] r_snap;
    logic [19:0] r_pre;
    logic        w_count_en;
    logic        w_tick;

    assign w_raw     = {lap_sw, start_sw};
    assign w_deb_stb = (r_deb_cnt == '0);

    // Level only changes on a full run of equal samples; mixed windows hold it.
    always_ff @(posedge clk0) begin
        if (reset_sw) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sh[0]   <= '0;
            r_sh[1]   <= '0;
            r_db      <= '0;
            r_db_d    <= '0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_db_d    <= r_db;
            r_deb_cnt <= (r_deb_cnt == DEB_LAST) ? '0 : r_deb_cnt + 21'd1;
            for (int unsigned b = 0; b < 2; b++) begin
                if (w_deb_stb) begin
                    r_sh[b] <= {r_sh[b][DEB_LEN-2:0], r_sync2[b]};
                end
                if (&r_sh[b]) begin
                    r_db[b] <= 1'b1;
                end else if (~|r_sh[b]) begin
                    r_db[b] <= 1'b0;
                end
            end
        end
    end

    assign w_press   = r_db & ~r_db_d;
    assign w_p_start = w_press[0];
    assign w_p_lap   = w_press[1];

    always_comb begin
        w_state_nx = r_state;
        w_clr_nx   = 1'b0;
        w_snap_ld  = 1'b0;
        w_flag_set = 1'b0;
        w_flag_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_p_start) begin
                    w_state_nx = ST_RUN;
                end else if (w_p_lap) begin
                    w_clr_nx = 1'b1;
                end
            end
            ST_RUN: begin
                if (ovf) begin
                    w_state_nx = ST_STOP;
                    w_flag_set = 1'b1;
                end else if (w_p_start) begin
                    w_state_nx = ST_STOP;
                end else if (w_p_lap) begin
                    w_state_nx = ST_LAP;
                    w_snap_ld  = 1'b1;
                end
            end
            ST_LAP: begin
                if (ovf) begin
                    w_state_nx = ST_STOP;
                    w_flag_set = 1'b1;
                end else if (w_p_start) begin
                    w_state_nx = ST_STOP;
                end else if (w_p_lap) begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_STOP: begin
                if (w_p_start) begin
                    w_state_nx = ST_RUN;
                end else if (w_p_lap) begin
                    w_state_nx = ST_IDLE;
                    w_clr_nx   = 1'b1;
                    w_flag_clr = 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign w_count_en = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign w_tick     = w_count_en && (r_pre == TICK_LAST);

    // Prescaler zeroes on the edge clr rises and holds in STOP to keep the fraction.
    always_ff @(posedge clk0) begin
        if (reset_sw) begin
            r_state    <= ST_IDLE;
            r_clr      <= 1'b0;
            r_ovf_flag <= 1'b0;
            r_snap     <= '0;
            r_pre      <= '0;
        end else begin
            r_state <= w_state_nx;
            r_clr   <= w_clr_nx;
            if (w_flag_set) begin
                r_ovf_flag <= 1'b1;
            end else if (w_flag_clr) begin
                r_ovf_flag <= 1'b0;
            end
            if (w_snap_ld) begin
                r_snap <= cnt_bcd;
            end
            if (w_clr_nx) begin
                r_pre <= '0;
            end else if (w_count_en) begin
                r_pre <= w_tick ? '0 : r_pre + 20'd1;
            end
        end
    end

    assign tick     = w_tick;
    assign clr      = r_clr;
    assign state    = r_state;
    assign ovf_flag = r_ovf_flag;
    assign disp_bcd = (r_state == ST_LAP) ? r_snap : cnt_bcd;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a cycle-indexed reference model
// built from sample histories, run lengths and enable-cycle counts.
module tb_stopwatch_ctrl;

    localparam int unsigned TICK_DIV = 5;
    localparam int unsigned DEB_DIV  = 4;
    localparam int unsigned DEB_LEN  = 3;
    localparam int unsigned MAXC     = 65536;

    logic        clk0 = 1'b0;
    logic        reset_sw;
    logic        start_sw;
    logic        lap_sw;
    logic [15:0] cnt_bcd;
    logic        ovf;
    logic        tick;
    logic        clr;
    logic [15:0] disp_bcd;
    logic [1:0]  state;
    logic        ovf_flag;

    always #5 clk0 = ~clk0;

    stopwatch_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DEB_DIV  (DEB_DIV),
        .DEB_LEN  (DEB_LEN)
    ) dut (
        .clk0     (clk0),
        .reset_sw (reset_sw),
        .start_sw (start_sw),
        .lap_sw   (lap_sw),
        .cnt_bcd  (cnt_bcd),
        .ovf      (ovf),
        .tick     (tick),
        .clr      (clr),
        .disp_bcd (disp_bcd),
        .state    (state),
        .ovf_flag (ovf_flag)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    typedef enum int {M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3} mstate_t;

    bit          m_valid = 1'b0;
    int unsigned m_cyc;
    bit          m_raw [0:1][0:MAXC-1];
    int unsigned m_run1 [2];
    int unsigned m_run0 [2];
    bit          m_lvl [2];
    bit          m_press [2];
    mstate_t     m_st;
    bit          m_clr;
    bit          m_flag;
    logic [15:0] m_snap;
    int unsigned m_encyc;

    // Advance the model across one rising edge, using the inputs of the ending cycle.
    task automatic model_step();
        int unsigned c;
        bit ps, pl, s, lvl_next;
        if (reset_sw) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            m_st    = M_IDLE;
            m_clr   = 1'b0;
            m_flag  = 1'b0;
            m_snap  = '0;
            m_encyc = 0;
            for (int b = 0; b < 2; b++) begin
                m_run1[b]  = 0;
                m_run0[b]  = DEB_LEN;
                m_lvl[b]   = 1'b0;
                m_press[b] = 1'b0;
            end
            return;
        end
        if (!m_valid) return;
        c = m_cyc;
        if (c < MAXC) begin
            m_raw[0][c] = start_sw;
            m_raw[1][c] = lap_sw;
        end
        ps = m_press[0];
        pl = m_press[1];
        if (m_st == M_RUN || m_st == M_LAP) m_encyc++;
        m_clr = 1'b0;
        case (m_st)
            M_IDLE: if (ps) m_st = M_RUN; else if (pl) m_clr = 1'b1;
            M_RUN: begin
                if (ovf) begin m_st = M_STOP; m_flag = 1'b1; end
                else if (ps) m_st = M_STOP;
                else if (pl) begin m_st = M_LAP; m_snap = cnt_bcd; end
            end
            M_LAP: begin
                if (ovf) begin m_st = M_STOP; m_flag = 1'b1; end
                else if (ps) m_st = M_STOP;
                else if (pl) m_st = M_RUN;
            end
            M_STOP: begin
                if (ps) m_st = M_RUN;
                else if (pl) begin m_st = M_IDLE; m_clr = 1'b1; m_flag = 1'b0; end
            end
            default: m_st = M_IDLE;
        endcase
        if (m_clr) m_encyc = 0;
        for (int b = 0; b < 2; b++) begin
            lvl_next = (m_run1[b] >= DEB_LEN) ? 1'b1 :
                       (m_run0[b] >= DEB_LEN) ? 1'b0 : m_lvl[b];
            if (c % DEB_DIV == 0) begin
                s = (c >= 2 && c - 2 < MAXC) ? m_raw[b][c-2] : 1'b0;
                if (s) begin
                    m_run1[b]++;
                    m_run0[b] = 0;
                end else begin
                    m_run0[b]++;
                    m_run1[b] = 0;
                end
            end
            m_press[b] = lvl_next && !m_lvl[b];
            m_lvl[b]   = lvl_next;
        end
        m_cyc++;
    endtask

    task automatic compare_outputs();
        bit en;
        if (m_valid) begin
            en = (m_st == M_RUN) || (m_st == M_LAP);
            check("state", state, m_st);
            check("tick", tick, en && (m_encyc % TICK_DIV == TICK_DIV - 1));
            check("clr", clr, m_clr);
            check("ovf_flag", ovf_flag, m_flag);
            check("disp_bcd", disp_bcd, (m_st == M_LAP) ? m_snap : cnt_bcd);
        end
    endtask

    task automatic cyc(input bit st, input bit lp, input bit ov, input bit rst);
        start_sw = st;
        lap_sw   = lp;
        ovf      = ov;
        reset_sw = rst;
        cnt_bcd  = 16'($urandom);
        @(negedge clk0);
        compare_outputs();
        @(posedge clk0);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Optional contact bounce, a stable hold long enough to debounce, then release.
    task automatic press(input bit s, input bit l, input bit bounce);
        if (bounce) begin
            for (int i = 0; i < 8; i++) begin
                bit t;
                t = 1'($urandom);
                cyc(s & t, l & t, 1'b0, 1'b0);
            end
        end
        repeat (20 + $urandom_range(0, 15))
            cyc(s, l, ($urandom_range(0, 40) == 0), 1'b0);
        repeat (22 + $urandom_range(0, 15))
            cyc(1'b0, 1'b0, ($urandom_range(0, 60) == 0), 1'b0);
    endtask

    initial begin
        start_sw = 1'b0;
        lap_sw   = 1'b0;
        ovf      = 1'b0;
        reset_sw = 1'b1;
        cnt_bcd  = '0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);

        // Bounce-only stimulus never settles to three high samples.
        for (int i = 0; i < 20; i++) cyc(1'(i % 2), 1'b0, 1'b0, 1'b0);
        idle(25);
        press(1'b1, 1'b0, 1'b0);
        idle(17);
        press(1'b0, 1'b1, 1'b1);
        idle(9);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        idle(50);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        idle(7);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        idle(13);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle(10);

        for (int a = 0; a < 250; a++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: press(1'b1, 1'b0, 1'($urandom));
                3, 4, 5: press(1'b0, 1'b1, 1'($urandom));
                6:       press(1'b1, 1'b1, 1'b0);
                7:       begin cyc(1'b0, 1'b0, 1'b1, 1'b0); idle($urandom_range(1, 10)); end
                8:       idle($urandom_range(1, 60));
                default: begin
                    repeat ($urandom_range(1, 2)) cyc(1'b0, 1'b0, 1'b0, 1'b1);
                    idle($urandom_range(1, 8));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
